uart_hex_monitor: RTL and testbench



---
 rtl/uart_hex_monitor_pkg.sv | 41 ++++
 rtl/uart_hex_monitor_if.sv | 22 ++
 rtl/uart_rx_os16.sv | 149 ++++++++++++++
 rtl/uart_hex_monitor.sv | 72 +++++++
 tb/tb_uart_hex_monitor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/uart_hex_monitor_pkg.sv
// Shared types and helpers for the UART hex monitor: receiver FSM states
// and the seven-segment nibble encoder.
package uart_mon_pkg;

  localparam int OS = 16;
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      4'hf: seg = 7'h0e;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/uart_hex_monitor_if.sv
// Serial line, display control and decoded outputs of the hex monitor;
// the monitor is the slave, the board/bench side is the master.
interface uart_hex_monitor_if;
  logic       rx;
  logic       display_clear;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  modport master (
    output rx, display_clear,
    input  byte_valid, byte_data, frame_err,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  rx, display_clear,
    output byte_valid, byte_data, frame_err,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 receiver with 16x oversampling. frame_ok_o/rx_byte_o expose the
// good-stop-sample strobe one clock early so the display can update in step.
module uart_rx_os16
  import uart_mon_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       frame_ok_o,
  output logic [7:0] rx_byte_o
);

  localparam int DIV   = CLK_HZ / (BAUD * OS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         tcnt_q, tcnt_d;
  logic [2:0]         bidx_q, bidx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               rx_s, tick_s, stop_smp_s;

  assign rx_s       = rx_sync_q;
  assign tick_s     = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));
  assign stop_smp_s = (state_q == STOP) && tick_s && (tcnt_q == 4'd15);

  // State register and all sequential datapath state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      div_q     <= '0;
      tcnt_q    <= 4'd0;
      bidx_q    <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      bidx_q    <= bidx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; the divider idles at 0 so tick phase follows the start edge
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    if (state_q == IDLE || tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    case (state_q)
      IDLE: begin
        tcnt_d = 4'd0;
        bidx_d = 3'd0;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s && tcnt_q == 4'd7) begin
          tcnt_d  = 4'd0;
          state_d = rx_s ? IDLE : DATA;
        end else if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            state_d = (bidx_q == 3'd7) ? STOP : DATA;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
        end else begin
          tcnt_d = tcnt_q;
        end
        if (stop_smp_s) begin
          state_d = rx_s ? IDLE : BREAK;
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: one-clock strobes and the held byte
  always_comb begin
    valid_d = stop_smp_s && rx_s;
    ferr_d  = stop_smp_s && !rx_s;
    if (valid_d) begin
      data_d = shift_q;
    end else begin
      data_d = data_q;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;
  assign frame_ok_o   = valid_d;
  assign rx_byte_o    = shift_q;

endmodule

// File: rtl/uart_hex_monitor.sv
// Top: UART receiver plus a four-byte display history shown as eight hex
// digits; HEX0 is the low nibble of the newest byte.
module uart_hex_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input logic               CLOCK_50,
  input logic               reset_n,
  uart_hex_monitor_if.slave mon
);

  logic        frame_ok_s;
  logic [7:0]  rx_byte_s;
  logic [31:0] disp_q, disp_d;
  logic [7:0]  mask_q, mask_d;
  logic [6:0]  hex_s [8];

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset_n),
    .rx_i         (mon.rx),
    .byte_valid_o (mon.byte_valid),
    .byte_data_o  (mon.byte_data),
    .frame_err_o  (mon.frame_err),
    .frame_ok_o   (frame_ok_s),
    .rx_byte_o    (rx_byte_s)
  );

  // Display history register and digit-valid mask
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      disp_q <= 32'h0;
      mask_q <= 8'h00;
    end else begin
      disp_q <= disp_d;
      mask_q <= mask_d;
    end
  end

  // Clear takes priority over a byte landing in the same cycle
  always_comb begin
    if (mon.display_clear) begin
      disp_d = 32'h0;
      mask_d = 8'h00;
    end else if (frame_ok_s) begin
      disp_d = {disp_q[23:0], rx_byte_s};
      mask_d = {mask_q[5:0], 2'b11};
    end else begin
      disp_d = disp_q;
      mask_d = mask_q;
    end
  end

  // Per-digit segment decode
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      hex_s[i] = mask_q[i] ? hex_to_seg(disp_q[4*i +: 4]) : SEG_BLANK;
    end
  end

  assign mon.HEX0 = hex_s[0];
  assign mon.HEX1 = hex_s[1];
  assign mon.HEX2 = hex_s[2];
  assign mon.HEX3 = hex_s[3];
  assign mon.HEX4 = hex_s[4];
  assign mon.HEX5 = hex_s[5];
  assign mon.HEX6 = hex_s[6];
  assign mon.HEX7 = hex_s[7];

endmodule

// File: tb/tb_uart_hex_monitor.sv
// Directed bench for uart_hex_monitor: serialises 8N1 frames at 432 clocks
// per bit and checks strobes, held byte and segment outputs.
module tb_uart_hex_monitor;

  localparam int BIT = 432;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   vcnt;
  int   ecnt;
  int   v0;
  int   e0;

  uart_hex_monitor_if bus ();

  uart_hex_monitor dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .mon      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) vcnt++;
    if (bus.frame_err === 1'b1) ecnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold_bits(input logic lvl, input int n);
    bus.rx = lvl;
    repeat (n * BIT) @(negedge clk);
  endtask

  // Full frame; optionally raise display_clear in the stop bit and drop it
  // right after the byte_valid cycle so that edge is the last cleared one.
  task automatic send(input logic [7:0] b, input logic stop, input logic clr);
    hold_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) hold_bits(b[i], 1);
    bus.rx = stop;
    if (clr) bus.display_clear = 1'b1;
    for (int c = 0; c < BIT; c++) begin
      @(negedge clk);
      if (clr && bus.display_clear && bus.byte_valid) bus.display_clear = 1'b0;
    end
    if (clr) chk("clr_window", {31'd0, bus.display_clear}, 32'd0);
    bus.display_clear = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    vcnt  = 0;
    ecnt  = 0;
    bus.rx = 1'b1;
    bus.display_clear = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_data", {24'd0, bus.byte_data}, 32'h00);
    chk("rst_hex0", {25'd0, bus.HEX0}, 32'h7f);
    chk("rst_hex7", {25'd0, bus.HEX7}, 32'h7f);
    rst_n = 1'b1;
    hold_bits(1'b1, 2);

    v0 = vcnt;
    send(8'h5a, 1'b1, 1'b0);
    hold_bits(1'b1, 1);
    chk("5a_cnt", vcnt - v0, 32'd1);
    chk("5a_data", {24'd0, bus.byte_data}, 32'h5a);
    chk("5a_hex1", {25'd0, bus.HEX1}, 32'h12);
    chk("5a_hex0", {25'd0, bus.HEX0}, 32'h08);
    chk("5a_hex2", {25'd0, bus.HEX2}, 32'h7f);
    chk("5a_hex7", {25'd0, bus.HEX7}, 32'h7f);

    v0 = vcnt;
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    send(8'h78, 1'b1, 1'b0);
    send(8'h9a, 1'b1, 1'b0);
    hold_bits(1'b1, 1);
    chk("b2b_cnt", vcnt - v0, 32'd5);
    chk("b2b_data", {24'd0, bus.byte_data}, 32'h9a);
    chk("b2b_hex",
        {4'd0, bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4},
        {4'd0, 7'h30, 7'h19, 7'h12, 7'h02});
    chk("b2b_hexlo",
        {4'd0, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0},
        {4'd0, 7'h78, 7'h00, 7'h10, 7'h08});

    v0 = vcnt;
    e0 = ecnt;
    bus.rx = 1'b0;
    repeat (100) @(negedge clk);
    hold_bits(1'b1, 2);
    chk("glitch_valid", vcnt - v0, 32'd0);
    chk("glitch_ferr", ecnt - e0, 32'd0);
    chk("glitch_hex7", {25'd0, bus.HEX7}, 32'h30);
    chk("glitch_hex0", {25'd0, bus.HEX0}, 32'h08);

    v0 = vcnt;
    e0 = ecnt;
    send(8'h00, 1'b0, 1'b0);
    hold_bits(1'b0, 2);
    hold_bits(1'b1, 1);
    chk("brk_ferr", ecnt - e0, 32'd1);
    chk("brk_valid", vcnt - v0, 32'd0);
    chk("brk_hex0", {25'd0, bus.HEX0}, 32'h08);
    send(8'hff, 1'b1, 1'b0);
    hold_bits(1'b1, 1);
    chk("ff_cnt", vcnt - v0, 32'd1);
    chk("ff_data", {24'd0, bus.byte_data}, 32'hff);
    chk("ff_hex10", {18'd0, bus.HEX1, bus.HEX0}, {18'd0, 7'h0e, 7'h0e});
    chk("ff_hex7", {25'd0, bus.HEX7}, 32'h12);

    send(8'h3c, 1'b1, 1'b1);
    hold_bits(1'b1, 1);
    chk("clr_data", {24'd0, bus.byte_data}, 32'h3c);
    chk("clr_hex10", {18'd0, bus.HEX1, bus.HEX0}, {18'd0, 7'h7f, 7'h7f});
    chk("clr_hex7", {25'd0, bus.HEX7}, 32'h7f);
    send(8'h01, 1'b1, 1'b0);
    hold_bits(1'b1, 1);
    chk("01_hex10", {18'd0, bus.HEX1, bus.HEX0}, {18'd0, 7'h40, 7'h79});
    chk("01_hex2", {25'd0, bus.HEX2}, 32'h7f);

    hold_bits(1'b0, 1);
    hold_bits(1'b1, 1);
    hold_bits(1'b0, 1);
    hold_bits(1'b1, 1);
    bus.rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, bus.byte_data}, 32'h00);
    chk("mid_rst_hex10", {18'd0, bus.HEX1, bus.HEX0}, {18'd0, 7'h7f, 7'h7f});
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    hold_bits(1'b1, 12);
    v0 = vcnt;
    send(8'ha5, 1'b1, 1'b0);
    hold_bits(1'b1, 1);
    chk("a5_cnt", vcnt - v0, 32'd1);
    chk("a5_data", {24'd0, bus.byte_data}, 32'ha5);
    chk("a5_hex10", {18'd0, bus.HEX1, bus.HEX0}, {18'd0, 7'h08, 7'h12});
    chk("a5_hex2", {25'd0, bus.HEX2}, 32'h7f);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
